// File: rtl/eth_pkt_pkg.sv
// Shared types and sizing helpers for the Ethernet packet FIFO write scheduler.
package eth_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int src_id_w(input int num_src);
    return (num_src <= 1) ? 1 : $clog2(num_src);
  endfunction

  function automatic int fifo_cap(input int depth_w);
    return 1 << depth_w;
  endfunction

endpackage

// File: rtl/eth_pkt_rr_arb.sv
// Combinational round-robin arbiter: the first eligible index at or after ptr wins.
module eth_pkt_rr_arb #(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_SRC-1:0] winner,
  output logic [ID_W-1:0]    win_idx,
  output logic               any
);

  int   idx;
  logic found;

  assign any = |eligible;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/eth_pkt_wr_sched.sv
// Write-side scheduler: round-robin admission of whole packets into a shared FIFO
// write port, gated by free space, with a completion report per packet.
module eth_pkt_wr_sched
  import eth_pkt_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int DATA_W  = 32,
  parameter  int DEPTH_W = 10,
  parameter  int LEN_W   = 11,
  localparam int ID_W    = src_id_w(NUM_SRC)
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*LEN_W-1:0]  src_len,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [NUM_SRC-1:0]        src_grant,
  output logic [NUM_SRC-1:0]        src_done,
  output logic [NUM_SRC-1:0]        src_reject,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      fifo_wr_en,
  input  logic                      fifo_wr_full,
  input  logic [DEPTH_W:0]          fifo_wr_water_level,
  output logic                      pkt_done,
  output logic [ID_W-1:0]           pkt_src,
  output logic [LEN_W-1:0]          pkt_len,
  output logic                      busy
);

  localparam logic [LEN_W-1:0] CAP_LEN = LEN_W'(fifo_cap(DEPTH_W));
  localparam logic [DEPTH_W:0] CAP_LVL = (DEPTH_W+1)'(fifo_cap(DEPTH_W));

  state_t               state, state_nxt;
  logic [ID_W-1:0]      ptr, ptr_nxt;
  logic [ID_W-1:0]      g, g_nxt;
  logic [LEN_W-1:0]     len_q, len_nxt;
  logic [LEN_W-1:0]     count, count_nxt;
  logic [NUM_SRC-1:0]   armed, armed_nxt;

  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   winner;
  logic [ID_W-1:0]      win_idx;
  logic                 any;

  logic [NUM_SRC-1:0]   g_onehot;
  logic [LEN_W-1:0]     sel_len;
  logic [DATA_W-1:0]    g_data;
  logic                 g_valid;
  logic [DEPTH_W:0]     free;
  logic                 len_bad;
  logic                 fits;
  logic [ID_W-1:0]      ptr_inc;
  logic                 wr;

  assign eligible = src_req & armed;

  eth_pkt_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (winner),
    .win_idx  (win_idx),
    .any      (any)
  );

  assign g_onehot = NUM_SRC'(1) << g;
  assign sel_len  = src_len[win_idx*LEN_W +: LEN_W];
  assign g_data   = src_data[g*DATA_W +: DATA_W];
  assign g_valid  = src_valid[g];
  // Water level never exceeds capacity, so free space cannot underflow.
  assign free     = CAP_LVL - fifo_wr_water_level;
  assign len_bad  = (len_q == '0) || (len_q > CAP_LEN);
  assign fits     = (len_q <= LEN_W'(free));
  assign ptr_inc  = (g == ID_W'(NUM_SRC-1)) ? '0 : g + ID_W'(1);
  assign wr       = (state == STREAM) && g_valid && !fifo_wr_full;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state <= IDLE;
      ptr   <= '0;
      g     <= '0;
      len_q <= '0;
      count <= '0;
      armed <= '1;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      g     <= g_nxt;
      len_q <= len_nxt;
      count <= count_nxt;
      armed <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    g_nxt        = g;
    len_nxt      = len_q;
    count_nxt    = count;
    // A source re-arms on any cycle its request is low.
    armed_nxt    = armed | ~src_req;
    src_ready    = '0;
    src_grant    = '0;
    src_done     = '0;
    src_reject   = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    pkt_done     = 1'b0;
    pkt_src      = '0;
    pkt_len      = '0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (any) begin
          g_nxt     = win_idx;
          len_nxt   = sel_len;
          armed_nxt = (armed & ~winner) | ~src_req;
          state_nxt = CHECK;
        end
      end

      CHECK: begin
        src_grant = g_onehot;
        if (len_bad) begin
          src_reject = g_onehot;
          ptr_nxt    = ptr_inc;
          state_nxt  = IDLE;
        end else if (fits) begin
          count_nxt = '0;
          state_nxt = STREAM;
        end
      end

      STREAM: begin
        src_grant    = g_onehot;
        src_ready    = g_onehot & {NUM_SRC{~fifo_wr_full}};
        fifo_wr_en   = wr;
        fifo_wr_data = g_data;
        if (wr) begin
          count_nxt = count + LEN_W'(1);
          if (count == len_q - LEN_W'(1)) state_nxt = DONE;
        end
      end

      DONE: begin
        pkt_done  = 1'b1;
        src_done  = g_onehot;
        pkt_src   = g;
        pkt_len   = len_q;
        ptr_nxt   = ptr_inc;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_pkt_wr_sched.sv
// Directed scoreboard bench for eth_pkt_wr_sched: expected FIFO writes and packet
// completions are queued as stimulus is driven and checked when the DUT emits them.
module tb_eth_pkt_wr_sched;

  localparam int NUM_SRC = 2;
  localparam int DATA_W  = 32;
  localparam int DEPTH_W = 10;
  localparam int LEN_W   = 11;
  localparam int ID_W    = 1;

  logic                      clk = 1'b0;
  logic                      wr_rst;
  logic [NUM_SRC-1:0]        src_req;
  logic [NUM_SRC*LEN_W-1:0]  src_len;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC-1:0]        src_grant;
  logic [NUM_SRC-1:0]        src_done;
  logic [NUM_SRC-1:0]        src_reject;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      fifo_wr_en;
  logic                      fifo_wr_full;
  logic [DEPTH_W:0]          fifo_wr_water_level;
  logic                      pkt_done;
  logic [ID_W-1:0]           pkt_src;
  logic [LEN_W-1:0]          pkt_len;
  logic                      busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DATA_W-1:0] wq[$];
  int                pq_src[$];
  int                pq_len[$];

  always #5 clk = ~clk;

  eth_pkt_wr_sched #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W),
    .LEN_W   (LEN_W)
  ) dut (
    .wr_clk              (clk),
    .wr_rst              (wr_rst),
    .src_req             (src_req),
    .src_len             (src_len),
    .src_data            (src_data),
    .src_valid           (src_valid),
    .src_ready           (src_ready),
    .src_grant           (src_grant),
    .src_done            (src_done),
    .src_reject          (src_reject),
    .fifo_wr_data        (fifo_wr_data),
    .fifo_wr_en          (fifo_wr_en),
    .fifo_wr_full        (fifo_wr_full),
    .fifo_wr_water_level (fifo_wr_water_level),
    .pkt_done            (pkt_done),
    .pkt_src             (pkt_src),
    .pkt_len             (pkt_len),
    .busy                (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int s, input logic req, input int len);
    src_req[s]                 = req;
    src_len[s*LEN_W +: LEN_W]  = len[LEN_W-1:0];
  endtask

  // Scoreboard consumer: every FIFO write and packet completion must match the queue head.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (wq.size() == 0) checkOutput("unexpected_write", fifo_wr_en, 0);
      else checkOutput("wr_data", fifo_wr_data, wq.pop_front());
    end
    if (pkt_done === 1'b1) begin
      if (pq_src.size() == 0) checkOutput("unexpected_pkt_done", pkt_done, 0);
      else begin
        checkOutput("pkt_src", pkt_src, pq_src.pop_front());
        checkOutput("pkt_len", pkt_len, pq_len.pop_front());
      end
    end
  end

  // One cycle from IDLE into CHECK; the grant must name s.
  task automatic expect_grant(input int s);
    tick();
    #1;
    checkOutput("grant", src_grant, 64'(1) << s);
    checkOutput("check_ready", src_ready, 0);
    checkOutput("check_wr_en", fifo_wr_en, 0);
    checkOutput("check_busy", busy, 1);
  endtask

  // Drives words while in STREAM; full is forced for 3 cycles starting at full_at.
  task automatic stream_words(input int s, input int n, input logic [DATA_W-1:0] base,
                              input bit gaps, input int full_at);
    int sent = 0;
    int cyc  = 0;
    bit v, f, acc;
    while (sent < n && cyc < 200) begin
      f = (full_at >= 0) && (cyc >= full_at) && (cyc < full_at + 3);
      v = f ? 1'b1 : (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      src_valid[s]                  = v;
      src_data[s*DATA_W +: DATA_W]  = base + DATA_W'(sent);
      fifo_wr_full                  = f;
      acc = v && !f;
      #1;
      checkOutput("src_ready", src_ready, f ? 64'd0 : (64'(1) << s));
      checkOutput("wr_en", fifo_wr_en, acc);
      if (acc) begin
        wq.push_back(base + DATA_W'(sent));
        sent++;
      end
      tick();
      cyc++;
    end
    src_valid[s] = 1'b0;
    fifo_wr_full = 1'b0;
    checkOutput("stream_budget", sent, n);
  endtask

  task automatic finish_packet(input int s, input int len, input logic [DATA_W-1:0] base,
                               input bit gaps, input int full_at, input bit drop);
    pq_src.push_back(s);
    pq_len.push_back(len);
    stream_words(s, len, base, gaps, full_at);
    #1;
    checkOutput("done_pulse", pkt_done, 1);
    checkOutput("src_done", src_done, 64'(1) << s);
    checkOutput("done_grant", src_grant, 0);
    checkOutput("done_wr_en", fifo_wr_en, 0);
    if (drop) src_req[s] = 1'b0;
    tick();
    #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", src_done, 0);
  endtask

  task automatic packet(input int s, input int len, input logic [DATA_W-1:0] base);
    expect_grant(s);
    tick();
    finish_packet(s, len, base, 1'b0, -1, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wr_rst              = 1'b1;
    src_req             = '0;
    src_len             = '0;
    src_data            = '0;
    src_valid           = '0;
    fifo_wr_full        = 1'b0;
    fifo_wr_water_level = '0;
    tick();
    tick();
    #1;
    checkOutput("rst_outs", {src_ready, src_grant, src_done, src_reject, fifo_wr_en,
                             pkt_done, busy, pkt_src, pkt_len}, 0);
    checkOutput("rst_data", fifo_wr_data, 0);
    wr_rst = 1'b0;
    tick();

    // Single packet from source 0.
    applyStimulus(0, 1'b1, 4);
    #1;
    checkOutput("t0_grant", src_grant, 0);
    checkOutput("t0_busy", busy, 0);
    expect_grant(0);
    tick();
    finish_packet(0, 4, 32'hA000_0000, 1'b0, -1, 1'b1);

    // Fairness with both sources requesting; pointer reset to 0 first.
    wr_rst = 1'b1;
    tick();
    wr_rst = 1'b0;
    tick();
    applyStimulus(0, 1'b1, 2);
    applyStimulus(1, 1'b1, 2);
    packet(0, 2, 32'hB000_0000);
    src_req[0] = 1'b1;
    packet(1, 2, 32'hB100_0000);
    src_req[1] = 1'b1;
    packet(0, 2, 32'hB200_0000);
    src_req[0] = 1'b1;
    packet(1, 2, 32'hB300_0000);
    src_req = '0;

    // Space admission: 4 words free blocks an 8-word packet until 8 are free.
    fifo_wr_water_level = 11'd1020;
    applyStimulus(0, 1'b1, 8);
    expect_grant(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checkOutput("hold_grant", src_grant, 1);
      checkOutput("hold_wr_en", fifo_wr_en, 0);
      checkOutput("hold_ready", src_ready, 0);
    end
    fifo_wr_water_level = 11'd1016;
    tick();
    finish_packet(0, 8, 32'hC000_0000, 1'b0, -1, 1'b1);
    fifo_wr_water_level = '0;

    // Stalls: valid gaps plus a 3-cycle full pulse.
    applyStimulus(1, 1'b1, 6);
    expect_grant(1);
    tick();
    finish_packet(1, 6, 32'hD000_0000, 1'b1, 2, 1'b1);

    // Reject len=0, then the other source is served.
    applyStimulus(0, 1'b1, 0);
    applyStimulus(1, 1'b1, 3);
    expect_grant(0);
    checkOutput("rej0_pulse", src_reject, 1);
    checkOutput("rej0_done", pkt_done, 0);
    src_req[0] = 1'b0;
    tick();
    #1;
    checkOutput("rej0_clear", src_reject, 0);
    expect_grant(1);
    tick();
    finish_packet(1, 3, 32'hE000_0000, 1'b0, -1, 1'b1);

    // Reject len=1025, then a 1-word packet from the other source.
    applyStimulus(0, 1'b1, 1025);
    expect_grant(0);
    checkOutput("rej1025_pulse", src_reject, 1);
    checkOutput("rej1025_done", pkt_done, 0);
    src_req[0] = 1'b0;
    applyStimulus(1, 1'b1, 1);
    tick();
    packet(1, 1, 32'hE100_0000);

    // Reset mid-STREAM with the pointer at 1, then re-arm behaviour.
    applyStimulus(0, 1'b1, 1);
    packet(0, 1, 32'hF000_0000);
    applyStimulus(1, 1'b1, 5);
    expect_grant(1);
    tick();
    stream_words(1, 2, 32'hF100_0000, 1'b0, -1);
    wr_rst    = 1'b1;
    src_valid = '0;
    applyStimulus(0, 1'b1, 2);
    tick();
    #1;
    checkOutput("midrst_outs", {src_ready, src_grant, src_done, src_reject, fifo_wr_en,
                                pkt_done, busy, pkt_src, pkt_len}, 0);
    checkOutput("midrst_data", fifo_wr_data, 0);
    wr_rst = 1'b0;
    expect_grant(0);
    src_req[1] = 1'b0;
    tick();
    finish_packet(0, 2, 32'hF200_0000, 1'b0, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checkOutput("no_regrant_busy", busy, 0);
      checkOutput("no_regrant_grant", src_grant, 0);
    end
    src_req[0] = 1'b0;
    tick();
    src_req[0] = 1'b1;
    expect_grant(0);
    tick();
    finish_packet(0, 2, 32'hF300_0000, 1'b0, -1, 1'b1);

    tick();
    tick();
    checkOutput("wq_drained", wq.size(), 0);
    checkOutput("pq_drained", pq_src.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
